pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the IF/ID pipeline register and PC for the 5-stage MIPS pipeline.
//  Detects load-use hazards, squashes wrong-path fetches on taken branches, and holds the front end for multi-cycle DIV.
//  Drives PC write enable, IF/ID write enable and flush, and ID/EX bubble insertion.
// PARAMETERS
//  DIV_LATENCY     34  cycles the front end is held after a DIV leaves ID (>=2)
//  BRANCH_PENALTY  1   cycles IF/ID is flushed after branch_taken (1..4)
//  CNT_W           32  width of performance counters
// PORTS
//  clk            in   1      pipeline clock, rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  ifid_rs        in   5      rs field of instruction in IF/ID
//  ifid_rt        in   5      rt field of instruction in IF/ID
//  ifid_uses_rt   in   1      ID instruction reads rt as a source
//  ifid_is_div    in   1      ID instruction is DIV/DIVU
//  idex_mem_read  in   1      EX instruction is a load
//  idex_rt        in   5      destination rt of EX load
//  branch_taken   in   1      EX resolved a taken branch/jump this cycle
//  pc_write       out  1      PC register load enable
//  ifid_write     out  1      IF/ID register load enable
//  ifid_flush     out  1      IF/ID loads NOP (0x00000000), PC_out 0
//  idex_bubble    out  1      ID/EX control fields zeroed
//  div_busy       out  1      high in DIV_WAIT
//  stall_cnt      out  CNT_W  stall cycles (see CONFIGURATION)
//  flush_cnt      out  CNT_W  flush events (see CONFIGURATION)
// BEHAVIOUR
//  - FSM states: RUN=2'd0, FLUSH=2'd1, DIV_WAIT=2'd2. State and down-counter div_cnt are registered.
//  - All enables are combinational from state plus inputs; they act in the same cycle (zero latency).
//  - While rst_n=0: state=RUN, div_cnt=0, counters=0.
//    Outputs forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, div_busy=0.
//  - load_use = idex_mem_read & (idex_rt!=0) & (idex_rt==ifid_rs | (ifid_uses_rt & idex_rt==ifid_rt)).
//  - RUN priority, highest first:
//    1) branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1.
//       Next state is FLUSH if BRANCH_PENALTY>1 (fl_cnt=BRANCH_PENALTY-2), else RUN.
//       A simultaneous load_use or DIV in ID is discarded.
//    2) load_use: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0 for one cycle; stay RUN.
//    3) ifid_is_div: all enables pass (DIV issues to EX). Next state DIV_WAIT, div_cnt=DIV_LATENCY-1.
//    4) otherwise: pc_write=1, ifid_write=1, flush=0, bubble=0.
//  - FLUSH: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1.
//    fl_cnt decrements each cycle; at fl_cnt==0 next state is RUN.
//  - DIV_WAIT: pc_write=0, ifid_write=0, idex_bubble=1, div_busy=1.
//    div_cnt decrements each cycle; when div_cnt==0 next state is RUN (front end released the following cycle).
//    branch_taken and load_use are ignored (EX holds bubbles); the bench asserts they never occur here.
//  - Reset asserted mid-DIV_WAIT or mid-FLUSH aborts immediately to RUN; no residual stall.
//  - Counters (macro on): stall_cnt +1 every cycle with pc_write=0 and rst_n=1.
//    flush_cnt +1 per branch_taken accepted in RUN. Both saturate at all-ones, never wrap.
// CONFIGURATION
//  - HAZARD_PERF_CNT_EN defined: stall_cnt/flush_cnt implemented as above.
//  - Not defined: ports remain, tied to 0, no counter flops.
// STRUCTURE
//  - Package mips_pipe_pkg: state enum (RUN/FLUSH/DIV_WAIT), REG_ZERO=5'd0, NOP_INSTR=32'h0.
//  - One sub-module, hazard_stall_timer: loadable down-counter with load/dec/zero flag.
//    Instantiated once and shared by FLUSH and DIV_WAIT (states are mutually exclusive).
// TESTING
//  - Reset: rst_n=0 mid-run -> pc_write=0, ifid_flush=1, idex_bubble=1 at once; release -> RUN, pc_write=1 next edge.
//  - Load-use: idex_mem_read=1, idex_rt=8, ifid_rs=8 -> one cycle pc_write=0, ifid_write=0, idex_bubble=1.
//    Same stimulus with idex_rt=0 -> no stall.
//  - rt-only hazard: idex_rt=9, ifid_rt=9, ifid_uses_rt=0 -> no stall; ifid_uses_rt=1 -> stall.
//  - Branch: BRANCH_PENALTY=2, branch_taken=1 together with load_use=1 -> flush in 2 consecutive cycles, no stall.
//    flush_cnt +1.
//  - DIV: DIV_LATENCY=4, ifid_is_div=1 -> issue cycle, then 4 cycles pc_write=0/div_busy=1, then RUN.
//    stall_cnt +4 (macro on).
//  - Reset in 2nd DIV_WAIT cycle -> div_busy=0 immediately; after release, no further stall cycles.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline front-end hazard control.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    DIV_WAIT = 2'd2
  } hz_state_e;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/hazard_stall_timer.sv
// Loadable down-counter shared by the FLUSH and DIV_WAIT states; saturates at zero.
module hazard_stall_timer #(
  parameter int unsigned W = 6
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// IF/ID and PC sequencing: load-use stall, branch flush, DIV front-end hold.
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DIV_LATENCY    = 34,
  parameter int unsigned BRANCH_PENALTY = 1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             ifid_is_div,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             div_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned TMAX = (DIV_LATENCY > BRANCH_PENALTY) ? DIV_LATENCY : BRANCH_PENALTY;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] DIV_LOAD = TW'(DIV_LATENCY - 1);
  localparam logic [TW-1:0] FL_LOAD  = (BRANCH_PENALTY > 1) ? TW'(BRANCH_PENALTY - 2) : '0;

  hz_state_e   state_q, state_d;
  logic        load_use;
  logic        tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0] tmr_load_val;

  assign load_use = idex_mem_read && (idex_rt != REG_ZERO) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  hazard_stall_timer #(
    .W (TW)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    div_busy     = 1'b0;
    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (BRANCH_PENALTY > 1) begin
            state_d      = FLUSH;
            tmr_load     = 1'b1;
            tmr_load_val = FL_LOAD;
          end
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else if (ifid_is_div) begin
          state_d      = DIV_WAIT;
          tmr_load     = 1'b1;
          tmr_load_val = DIV_LOAD;
        end
      end
      FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        tmr_dec     = 1'b1;
        if (tmr_zero) state_d = RUN;
      end
      DIV_WAIT: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        div_busy    = 1'b1;
        tmr_dec     = 1'b1;
        if (tmr_zero) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    // Reset overrides every enable combinationally, not just at the next edge.
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      div_busy    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             br_accept;

  assign br_accept = (state_q == RUN) && branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (br_accept && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
